// File: rtl/dma_desc_arb_pkg.sv
// Shared helpers for the read-descriptor arbiter: port-index sizing and the
// packing of {port_index, requester_tag} into the client-side tag.
package dma_desc_arb_pkg;

    // Width of a port index; never less than one bit.
    function automatic int port_idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Build the client tag: port index above the requester tag bits.
    function automatic logic [63:0] tag_pack(input logic [31:0] port_idx,
                                             input logic [31:0] s_tag,
                                             input int          s_tag_width);
        return (64'(port_idx) << s_tag_width) | 64'(s_tag);
    endfunction

    // Recover the port index from a client tag.
    function automatic logic [31:0] tag_port(input logic [63:0] m_tag,
                                             input int          s_tag_width);
        return 32'(m_tag >> s_tag_width);
    endfunction

endpackage

// File: rtl/dma_client_read_desc_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester after the last
// winner; the priority pointer moves only when a grant is issued.
module rr_arbiter
    import dma_desc_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = port_idx_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req_i,
    input  logic             en_i,
    output logic [PORTS-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [PORTS-1:0] req_rot_s;
    logic [PORTS-1:0] low_s;

    // Rotate requests so last_grant+1 sits at bit 0, isolate the lowest set
    // bit, then rotate back to absolute port positions.
    always_comb begin
        req_rot_s     = PORTS'({req_i, req_i} >> (int'(last_q) + 1));
        low_s         = req_rot_s & (~req_rot_s + PORTS'(1));
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        if (en_i) begin
            grant_o       = PORTS'(({low_s, low_s} << (int'(last_q) + 1)) >> PORTS);
            grant_valid_o = |req_rot_s;
        end else begin
            grant_valid_o = 1'b0;
        end
        for (int p = 0; p < PORTS; p++) begin
            grant_idx_o = grant_idx_o | (IDX_W'(p) & {IDX_W{grant_o[p]}});
        end
    end

    // Priority pointer follows the winner.
    always_comb begin
        if (grant_valid_o) begin
            last_d = grant_idx_o;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset so port 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dma_client_read_desc_arb.sv
// Shares one dma_client_axis_source read-descriptor interface between PORTS
// requesters. Forwarded tags carry the granted port index in their upper bits;
// completions are routed back by that index.
// Optional per-port in-flight limit: define DMA_DESC_ARB_OUTSTANDING_LIMIT_EN.
module dma_client_read_desc_arb
    import dma_desc_arb_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 8,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]    s_axis_read_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_read_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_tag,
    input  logic [PORTS*AXIS_ID_WIDTH-1:0]     s_axis_read_desc_id,
    input  logic [PORTS*AXIS_DEST_WIDTH-1:0]   s_axis_read_desc_dest,
    input  logic [PORTS*AXIS_USER_WIDTH-1:0]   s_axis_read_desc_user,
    input  logic [PORTS-1:0]                   s_axis_read_desc_valid,
    output logic [PORTS-1:0]                   s_axis_read_desc_ready,
    output logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_status_tag,
    output logic [PORTS-1:0]                   s_axis_read_desc_status_valid,
    output logic [RAM_ADDR_WIDTH-1:0]          m_axis_read_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]               m_axis_read_desc_len,
    output logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_tag,
    output logic [AXIS_ID_WIDTH-1:0]           m_axis_read_desc_id,
    output logic [AXIS_DEST_WIDTH-1:0]         m_axis_read_desc_dest,
    output logic [AXIS_USER_WIDTH-1:0]         m_axis_read_desc_user,
    output logic                               m_axis_read_desc_valid,
    input  logic                               m_axis_read_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_status_tag,
    input  logic                               m_axis_read_desc_status_valid
);

    localparam int IDX_W = port_idx_width(PORTS);

    logic [PORTS-1:0]           mask_s;
    logic [PORTS-1:0]           elig_s;
    logic [PORTS-1:0]           grant_s;
    logic [IDX_W-1:0]           grant_idx_s;
    logic                       grant_valid_s;
    logic                       load_s;

    logic [RAM_ADDR_WIDTH-1:0]  sel_addr_s;
    logic [LEN_WIDTH-1:0]       sel_len_s;
    logic [S_TAG_WIDTH-1:0]     sel_tag_s;
    logic [AXIS_ID_WIDTH-1:0]   sel_id_s;
    logic [AXIS_DEST_WIDTH-1:0] sel_dest_s;
    logic [AXIS_USER_WIDTH-1:0] sel_user_s;

    logic                       m_valid_q, m_valid_d;
    logic [RAM_ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
    logic [LEN_WIDTH-1:0]       m_len_q, m_len_d;
    logic [M_TAG_WIDTH-1:0]     m_tag_q, m_tag_d;
    logic [AXIS_ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic [AXIS_DEST_WIDTH-1:0] m_dest_q, m_dest_d;
    logic [AXIS_USER_WIDTH-1:0] m_user_q, m_user_d;

    logic [PORTS-1:0]           stat_valid_q, stat_valid_d;
    logic [S_TAG_WIDTH-1:0]     stat_tag_q, stat_tag_d;

    // The output register can take a new descriptor when empty or draining.
    assign load_s = !m_valid_q || m_axis_read_desc_ready;
    assign elig_s = s_axis_read_desc_valid & ~mask_s;

    rr_arbiter #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (elig_s),
        .en_i          (load_s),
        .grant_o       (grant_s),
        .grant_idx_o   (grant_idx_s),
        .grant_valid_o (grant_valid_s)
    );

    assign s_axis_read_desc_ready = grant_s;

    // AND-OR mux of the granted port's fields (grant is one-hot).
    always_comb begin
        sel_addr_s = '0;
        sel_len_s  = '0;
        sel_tag_s  = '0;
        sel_id_s   = '0;
        sel_dest_s = '0;
        sel_user_s = '0;
        for (int p = 0; p < PORTS; p++) begin
            sel_addr_s = sel_addr_s | (s_axis_read_desc_ram_addr[p*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] & {RAM_ADDR_WIDTH{grant_s[p]}});
            sel_len_s  = sel_len_s  | (s_axis_read_desc_len[p*LEN_WIDTH +: LEN_WIDTH] & {LEN_WIDTH{grant_s[p]}});
            sel_tag_s  = sel_tag_s  | (s_axis_read_desc_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH] & {S_TAG_WIDTH{grant_s[p]}});
            sel_id_s   = sel_id_s   | (s_axis_read_desc_id[p*AXIS_ID_WIDTH +: AXIS_ID_WIDTH] & {AXIS_ID_WIDTH{grant_s[p]}});
            sel_dest_s = sel_dest_s | (s_axis_read_desc_dest[p*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH] & {AXIS_DEST_WIDTH{grant_s[p]}});
            sel_user_s = sel_user_s | (s_axis_read_desc_user[p*AXIS_USER_WIDTH +: AXIS_USER_WIDTH] & {AXIS_USER_WIDTH{grant_s[p]}});
        end
    end

    // Output register: load on grant, clear when drained without a refill.
    always_comb begin
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_tag_d   = m_tag_q;
        m_id_d    = m_id_q;
        m_dest_d  = m_dest_q;
        m_user_d  = m_user_q;
        if (grant_valid_s) begin
            m_valid_d = 1'b1;
            m_addr_d  = sel_addr_s;
            m_len_d   = sel_len_s;
            m_tag_d   = M_TAG_WIDTH'(tag_pack(32'(grant_idx_s), 32'(sel_tag_s), S_TAG_WIDTH));
            m_id_d    = sel_id_s;
            m_dest_d  = sel_dest_s;
            m_user_d  = sel_user_s;
        end else if (m_valid_q && m_axis_read_desc_ready) begin
            m_valid_d = 1'b0;
            m_addr_d  = '0;
            m_len_d   = '0;
            m_tag_d   = '0;
            m_id_d    = '0;
            m_dest_d  = '0;
            m_user_d  = '0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Status demux: strobe only the port named by the tag's upper bits; an
    // index with no matching port simply strobes nothing.
    always_comb begin
        stat_valid_d = '0;
        stat_tag_d   = stat_tag_q;
        if (m_axis_read_desc_status_valid) begin
            stat_tag_d = m_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
            for (int p = 0; p < PORTS; p++) begin
                stat_valid_d[p] = (tag_port(64'(m_axis_read_desc_status_tag), S_TAG_WIDTH) == 32'(p));
            end
        end else begin
            stat_valid_d = '0;
        end
    end

    // Descriptor and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_len_q      <= '0;
            m_tag_q      <= '0;
            m_id_q       <= '0;
            m_dest_q     <= '0;
            m_user_q     <= '0;
            stat_valid_q <= '0;
            stat_tag_q   <= '0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_len_q      <= m_len_d;
            m_tag_q      <= m_tag_d;
            m_id_q       <= m_id_d;
            m_dest_q     <= m_dest_d;
            m_user_q     <= m_user_d;
            stat_valid_q <= stat_valid_d;
            stat_tag_q   <= stat_tag_d;
        end
    end

`ifdef DMA_DESC_ARB_OUTSTANDING_LIMIT_EN
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q [PORTS];
    logic [CNT_W-1:0] cnt_d [PORTS];

    // A port at its limit drops out of arbitration.
    always_comb begin
        mask_s = '0;
        for (int p = 0; p < PORTS; p++) begin
            mask_s[p] = (cnt_q[p] == CNT_MAX);
        end
    end

    // In-flight count: +1 on accept, -1 on routed status, saturating at 0.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            case ({grant_s[p], stat_valid_d[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CNT_W'(1);
                2'b01:   cnt_d[p] = (cnt_q[p] != '0) ? cnt_q[p] - CNT_W'(1) : cnt_q[p];
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end
`else
    // No in-flight limit: every port stays eligible for any legal limit value.
    assign mask_s = {PORTS{MAX_OUTSTANDING < 0}};
`endif

    assign m_axis_read_desc_valid    = m_valid_q;
    assign m_axis_read_desc_ram_addr = m_addr_q;
    assign m_axis_read_desc_len      = m_len_q;
    assign m_axis_read_desc_tag      = m_tag_q;
    assign m_axis_read_desc_id       = m_id_q;
    assign m_axis_read_desc_dest     = m_dest_q;
    assign m_axis_read_desc_user     = m_user_q;
    assign s_axis_read_desc_status_valid = stat_valid_q;
    assign s_axis_read_desc_status_tag   = {PORTS{stat_tag_q}};

endmodule

// File: tb/tb_dma_client_read_desc_arb.sv
// Bench for dma_client_read_desc_arb: directed scenarios plus a random run,
// all checked against a cycle-level behavioural model of the arbiter.
`timescale 1ns/1ps
module tb_dma_client_read_desc_arb;

    localparam int P   = 4;
    localparam int AW  = 16;
    localparam int LW  = 20;
    localparam int STW = 8;
    localparam int PIW = 2;
    localparam int MTW = STW + PIW;
    localparam int IW  = 8;
    localparam int DW  = 8;
    localparam int UW  = 1;
`ifdef DMA_DESC_ARB_OUTSTANDING_LIMIT_EN
    localparam int MO    = 2;
    localparam bit LIMIT = 1'b1;
`else
    localparam int MO    = 8;
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]  p_addr [P];
    logic [LW-1:0]  p_len  [P];
    logic [STW-1:0] p_tag  [P];
    logic [IW-1:0]  p_id   [P];
    logic [DW-1:0]  p_dest [P];
    logic [UW-1:0]  p_user [P];

    logic [P*AW-1:0]  s_addr;
    logic [P*LW-1:0]  s_len;
    logic [P*STW-1:0] s_tag;
    logic [P*IW-1:0]  s_id;
    logic [P*DW-1:0]  s_dest;
    logic [P*UW-1:0]  s_user;
    logic [P-1:0]     s_valid = '0;
    logic [P-1:0]     s_ready;
    logic [P*STW-1:0] s_stat_tag;
    logic [P-1:0]     s_stat_valid;
    logic [AW-1:0]    m_addr;
    logic [LW-1:0]    m_len;
    logic [MTW-1:0]   m_tag;
    logic [IW-1:0]    m_id;
    logic [DW-1:0]    m_dest;
    logic [UW-1:0]    m_user;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [MTW-1:0]   m_stat_tag = '0;
    logic             m_stat_valid = 1'b0;

    for (genvar g = 0; g < P; g++) begin : g_pack
        assign s_addr[g*AW +: AW]   = p_addr[g];
        assign s_len[g*LW +: LW]    = p_len[g];
        assign s_tag[g*STW +: STW]  = p_tag[g];
        assign s_id[g*IW +: IW]     = p_id[g];
        assign s_dest[g*DW +: DW]   = p_dest[g];
        assign s_user[g*UW +: UW]   = p_user[g];
    end

    dma_client_read_desc_arb #(
        .PORTS(P), .RAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .S_TAG_WIDTH(STW),
        .M_TAG_WIDTH(MTW), .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW),
        .AXIS_USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_read_desc_ram_addr(s_addr), .s_axis_read_desc_len(s_len),
        .s_axis_read_desc_tag(s_tag), .s_axis_read_desc_id(s_id),
        .s_axis_read_desc_dest(s_dest), .s_axis_read_desc_user(s_user),
        .s_axis_read_desc_valid(s_valid), .s_axis_read_desc_ready(s_ready),
        .s_axis_read_desc_status_tag(s_stat_tag),
        .s_axis_read_desc_status_valid(s_stat_valid),
        .m_axis_read_desc_ram_addr(m_addr), .m_axis_read_desc_len(m_len),
        .m_axis_read_desc_tag(m_tag), .m_axis_read_desc_id(m_id),
        .m_axis_read_desc_dest(m_dest), .m_axis_read_desc_user(m_user),
        .m_axis_read_desc_valid(m_valid), .m_axis_read_desc_ready(m_ready),
        .m_axis_read_desc_status_tag(m_stat_tag),
        .m_axis_read_desc_status_valid(m_stat_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    int             mdl_last;
    bit             mdl_mv;
    logic [AW-1:0]  mdl_addr;
    logic [LW-1:0]  mdl_len;
    logic [MTW-1:0] mdl_tag;
    logic [IW-1:0]  mdl_id;
    logic [DW-1:0]  mdl_dest;
    logic [UW-1:0]  mdl_user;
    logic [P-1:0]   mdl_sv;
    logic [STW-1:0] mdl_st;
    int             mdl_cnt [P];

    task automatic mdl_clear_desc();
        mdl_mv = 1'b0; mdl_addr = '0; mdl_len = '0; mdl_tag = '0;
        mdl_id = '0; mdl_dest = '0; mdl_user = '0;
    endtask

    task automatic mdl_reset();
        mdl_last = P - 1;
        mdl_clear_desc();
        mdl_sv = '0;
        mdl_st = '0;
        for (int p = 0; p < P; p++) mdl_cnt[p] = 0;
    endtask

    // Port the model would grant this cycle, or -1.
    function automatic int mdl_pick();
        int c;
        if (mdl_mv && !m_ready) return -1;
        for (int k = 1; k <= P; k++) begin
            c = (mdl_last + k) % P;
            if (s_valid[c] && (!LIMIT || mdl_cnt[c] < MO)) return c;
        end
        return -1;
    endfunction

    function automatic logic [P-1:0] mdl_ready();
        logic [P-1:0] r;
        int c;
        r = '0;
        c = mdl_pick();
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    task automatic randomize_fields();
        for (int p = 0; p < P; p++) begin
            p_addr[p] = AW'($urandom);
            p_len[p]  = LW'($urandom);
            p_tag[p]  = STW'($urandom);
            p_id[p]   = IW'($urandom);
            p_dest[p] = DW'($urandom);
            p_user[p] = UW'($urandom);
        end
    endtask

    // Advance one clock, updating the model from the inputs of this cycle.
    task automatic tick();
        int c, sp;
        bit sv_in;
        logic [STW-1:0] st_in;
        c     = mdl_pick();
        sp    = int'(m_stat_tag >> STW);
        sv_in = m_stat_valid;
        st_in = m_stat_tag[STW-1:0];
        @(posedge clk);
        if (LIMIT) begin
            for (int p = 0; p < P; p++) begin
                if (c == p && !(sv_in && sp == p)) mdl_cnt[p]++;
                else if (c != p && sv_in && sp == p && mdl_cnt[p] > 0) mdl_cnt[p]--;
            end
        end
        if (c >= 0) begin
            mdl_mv = 1'b1; mdl_addr = p_addr[c]; mdl_len = p_len[c];
            mdl_tag = {PIW'(c), p_tag[c]}; mdl_id = p_id[c];
            mdl_dest = p_dest[c]; mdl_user = p_user[c]; mdl_last = c;
        end else if (mdl_mv && m_ready) begin
            mdl_clear_desc();
        end
        mdl_sv = '0;
        if (sv_in) begin
            mdl_st = st_in;
            if (sp < P) mdl_sv[sp] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [AW+LW+MTW+IW+DW+UW-1:0] mdat;
        rst_n = 1'b0; s_valid = '0; m_ready = 1'b0; m_stat_valid = 1'b0; m_stat_tag = '0;
        randomize_fields();
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        mdat = {m_addr, m_len, m_tag, m_id, m_dest, m_user};
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_vec++; if (mdat !== '0) begin n_err++; $display("FAIL reset_m_data got %h want 0", mdat); end
        n_vec++; if (s_ready !== '0) begin n_err++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        n_vec++; if (s_stat_valid !== '0) begin n_err++; $display("FAIL reset_stat_valid got %b want 0", s_stat_valid); end
        n_vec++; if (s_stat_tag !== '0) begin n_err++; $display("FAIL reset_stat_tag got %h want 0", s_stat_tag); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotation();
        logic [P-1:0] want;
        s_valid = '1; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            randomize_fields();
            #1;
            want = '0; want[i % P] = 1'b1;
            n_vec++; if (s_ready !== want || s_ready !== mdl_ready()) begin
                n_err++; $display("FAIL rot_ready cyc %0d got %b want %b", i, s_ready, want);
            end
            tick();
            n_vec++; if (m_valid !== 1'b1 || m_tag !== {PIW'(i % P), p_tag[i % P]} || m_addr !== p_addr[i % P]) begin
                n_err++; $display("FAIL rot_desc cyc %0d got v=%b tag=%h addr=%h want v=1 tag=%h addr=%h",
                                  i, m_valid, m_tag, m_addr, {PIW'(i % P), p_tag[i % P]}, p_addr[i % P]);
            end
        end
        s_valid = '0;
        tick();
    endtask

    task automatic test_single_port();
        randomize_fields();
        p_tag[2] = 8'h15; s_valid = 4'b0100; m_ready = 1'b1;
        #1;
        n_vec++; if (s_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", s_ready); end
        tick();
        s_valid = '0;
        n_vec++; if (m_valid !== 1'b1 || m_tag !== 10'h215 || m_addr !== p_addr[2] || m_len !== p_len[2]) begin
            n_err++; $display("FAIL single_desc got v=%b tag=%h addr=%h want v=1 tag=215 addr=%h", m_valid, m_tag, m_addr, p_addr[2]);
        end
        m_stat_tag = 10'h215; m_stat_valid = 1'b1;
        #1;
        tick();
        m_stat_valid = 1'b0;
        n_vec++; if (s_stat_valid !== 4'b0100 || s_stat_tag !== {P{8'h15}}) begin
            n_err++; $display("FAIL single_status got v=%b tag=%h want v=0100 tag=15151515", s_stat_valid, s_stat_tag);
        end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", m_valid); end
        tick();
        n_vec++; if (s_stat_valid !== 4'b0000) begin n_err++; $display("FAIL single_strobe got %b want 0000", s_stat_valid); end
    endtask

    task automatic test_backpressure();
        int g;
        logic [MTW-1:0] held_tag;
        logic [AW-1:0]  held_addr;
        logic [P-1:0]   want;
        randomize_fields();
        s_valid = '1; m_ready = 1'b1;
        #1;
        g = mdl_pick();
        held_tag = {PIW'(g), p_tag[g]}; held_addr = p_addr[g];
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_fields();
            #1;
            n_vec++; if (s_ready !== '0) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want 0", i, s_ready); end
            tick();
            n_vec++; if (m_valid !== 1'b1 || m_tag !== held_tag || m_addr !== held_addr) begin
                n_err++; $display("FAIL bp_hold cyc %0d got v=%b tag=%h addr=%h want v=1 tag=%h addr=%h",
                                  i, m_valid, m_tag, m_addr, held_tag, held_addr);
            end
        end
        m_ready = 1'b1;
        #1;
        want = '0; want[(g + 1) % P] = 1'b1;
        n_vec++; if (s_ready !== want) begin n_err++; $display("FAIL bp_resume got %b want %b", s_ready, want); end
        tick();
        n_vec++; if (m_tag !== {PIW'((g + 1) % P), p_tag[(g + 1) % P]}) begin
            n_err++; $display("FAIL bp_next_tag got %h want %h", m_tag, {PIW'((g + 1) % P), p_tag[(g + 1) % P]});
        end
        s_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [P-1:0] exp_r;
        for (int i = 0; i < 400; i++) begin
            randomize_fields();
            s_valid      = P'($urandom);
            m_ready      = ($urandom_range(0, 3) != 0);
            m_stat_valid = ($urandom_range(0, 2) == 0);
            m_stat_tag   = MTW'($urandom);
            #1;
            exp_r = mdl_ready();
            n_vec++; if (s_ready !== exp_r || $countones(s_ready) > 1) begin
                n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, s_ready, exp_r);
            end
            tick();
            n_vec++; if (m_valid !== mdl_mv ||
                         {m_addr, m_len, m_tag, m_id, m_dest, m_user} !== {mdl_addr, mdl_len, mdl_tag, mdl_id, mdl_dest, mdl_user}) begin
                n_err++; $display("FAIL rnd_desc cyc %0d got v=%b tag=%h addr=%h want v=%b tag=%h addr=%h",
                                  i, m_valid, m_tag, m_addr, mdl_mv, mdl_tag, mdl_addr);
            end
            n_vec++; if (s_stat_valid !== mdl_sv || s_stat_tag !== {P{mdl_st}}) begin
                n_err++; $display("FAIL rnd_status cyc %0d got v=%b tag=%h want v=%b tag=%h",
                                  i, s_stat_valid, s_stat_tag, mdl_sv, {P{mdl_st}});
            end
        end
        s_valid = '0; m_stat_valid = 1'b0; m_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        randomize_fields();
        s_valid = 4'b0010; m_ready = 1'b0;
        #1;
        tick();
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_loaded got %b want 1", m_valid); end
        s_valid = '0;
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        n_vec++; if (m_valid !== 1'b0 || m_tag !== '0) begin
            n_err++; $display("FAIL rstmid_drop got v=%b tag=%h want v=0 tag=0", m_valid, m_tag);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_valid = '1; m_ready = 1'b1;
        #1;
        n_vec++; if (s_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_first got %b want 0001", s_ready); end
        tick();
        s_valid = '0;
        m_stat_tag = {2'd1, 8'h5A}; m_stat_valid = 1'b1;
        n_vec++; if (m_valid !== 1'b1 || m_tag[MTW-1:STW] !== 2'd0) begin
            n_err++; $display("FAIL rstmid_port0 got v=%b tag=%h want v=1 port 0", m_valid, m_tag);
        end
        tick();
        m_stat_valid = 1'b0;
        n_vec++; if (s_stat_valid !== 4'b0010 || s_stat_tag[STW-1:0] !== 8'h5A) begin
            n_err++; $display("FAIL rstmid_status got v=%b tag=%h want v=0010 tag=5a", s_stat_valid, s_stat_tag);
        end
        tick();
    endtask

`ifdef DMA_DESC_ARB_OUTSTANDING_LIMIT_EN
    task automatic test_outstanding();
        logic [P-1:0] want;
        rst_n = 1'b0; s_valid = '0; m_stat_valid = 1'b0;
        mdl_reset();
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; m_ready = 1'b1;
        randomize_fields();
        s_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            want = (i < 2) ? 4'b0001 : 4'b0000;
            n_vec++; if (s_ready !== want) begin n_err++; $display("FAIL lim_p0 cyc %0d got %b want %b", i, s_ready, want); end
            tick();
        end
        m_stat_tag = {2'd0, 8'h33}; m_stat_valid = 1'b1;
        #1;
        n_vec++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL lim_stall got %b want 0000", s_ready); end
        tick();
        m_stat_valid = 1'b0;
        #1;
        n_vec++; if (s_ready !== 4'b0001) begin n_err++; $display("FAIL lim_release got %b want 0001", s_ready); end
        tick();
        s_valid = 4'b0010;
        #1;
        n_vec++; if (s_ready !== 4'b0010) begin n_err++; $display("FAIL lim_p1_a got %b want 0010", s_ready); end
        tick();
        m_stat_tag = {2'd1, 8'h44}; m_stat_valid = 1'b1;
        #1;
        n_vec++; if (s_ready !== 4'b0010) begin n_err++; $display("FAIL lim_p1_b got %b want 0010", s_ready); end
        tick();
        m_stat_valid = 1'b0;
        #1;
        n_vec++; if (s_ready !== 4'b0010) begin n_err++; $display("FAIL lim_p1_c got %b want 0010", s_ready); end
        tick();
        #1;
        n_vec++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL lim_p1_full got %b want 0000", s_ready); end
        s_valid = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_single_port();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef DMA_DESC_ARB_OUTSTANDING_LIMIT_EN
        test_outstanding();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
